sipo_demux8: RTL and testbench

//   Receiving end of the 8:1 mux bit-serial path: collects one serial bit per accepted cycle and

---
 rtl/sipo_demux8.sv | 207 ++++++++++++++++++++
 tb/tb_sipo_demux8.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_demux8.sv
// Serial-in, parallel-out receiver: demultiplexes one bit per accepted cycle into a word
// and presents completed words on a valid/ready port. Optional trailing parity: SIPO_PARITY_EN.
`default_nettype none

module sipo_demux8 #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int SEL_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [SEL_W-1:0] sel_out,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
`ifdef SIPO_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;

    logic             accept_s;
    logic             out_free_s;
    logic [CNT_W-1:0] slot_s;
    logic [WIDTH-1:0] shift_ins_s;
    logic [WIDTH-1:0] word_s;

`ifdef SIPO_PARITY_EN
    logic perr_q, perr_d;
    logic pend_perr_q, pend_perr_d;
    logic word_perr_s;
`endif

    assign din_ready  = (state_q == ST_COLLECT);
    assign accept_s   = din_valid & din_ready;
    assign out_free_s = ~dout_valid_q | dout_ready;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    // Slot index for the current bit, mirrored when the word arrives MSB first.
    always_comb begin
        if (LSB_FIRST) begin
            slot_s = cnt_q;
        end else begin
            slot_s = DATA_LAST - cnt_q;
        end
    end

    // Shift register image with the incoming bit written into its slot.
    always_comb begin
        shift_ins_s = shift_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (slot_s == CNT_W'(k)) begin
                shift_ins_s[k] = din;
            end else begin
                shift_ins_s[k] = shift_q[k];
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // The completing accept carries the parity bit, so the data is already in the shift reg.
    always_comb begin
        word_s      = shift_q;
        word_perr_s = (^shift_q) ^ din;
    end

    // The parity slot keeps sel_out on the last data slot.
    always_comb begin
        if (state_q != ST_COLLECT) begin
            sel_out = {SEL_W{1'b0}};
        end else if (cnt_q == LAST_CNT) begin
            sel_out = SEL_W'(WIDTH - 1);
        end else begin
            sel_out = SEL_W'(cnt_q);
        end
    end

    assign parity_err = perr_q;
`else
    // The completing accept carries the last data bit itself.
    always_comb begin
        word_s = shift_ins_s;
    end

    // Slot index follows the bit counter while collecting.
    always_comb begin
        if (state_q != ST_COLLECT) begin
            sel_out = {SEL_W{1'b0}};
        end else begin
            sel_out = SEL_W'(cnt_q);
        end
    end

    assign parity_err = 1'b0;
`endif

    // Next-state logic: collection, word hand-off and output register update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q & ~dout_ready;
`ifdef SIPO_PARITY_EN
        perr_d       = perr_q;
        pend_perr_d  = pend_perr_q;
`endif
        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (out_free_s) begin
                            dout_d       = word_s;
                            dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                            perr_d       = word_perr_s;
`endif
                        end else begin
                            // Sink stalled: park the finished word and stop accepting.
                            shift_d     = word_s;
                            state_d     = ST_FULL;
`ifdef SIPO_PARITY_EN
                            pend_perr_d = word_perr_s;
`endif
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = shift_ins_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_FULL: begin
                cnt_d = {CNT_W{1'b0}};
                if (out_free_s) begin
                    dout_d       = shift_q;
                    dout_valid_d = 1'b1;
                    state_d      = ST_COLLECT;
`ifdef SIPO_PARITY_EN
                    perr_d       = pend_perr_q;
`endif
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_COLLECT;
            cnt_q        <= {CNT_W{1'b0}};
            shift_q      <= {WIDTH{1'b0}};
            dout_q       <= {WIDTH{1'b0}};
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

`ifdef SIPO_PARITY_EN
    // Parity status registers, loaded together with dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q      <= 1'b0;
            pend_perr_q <= 1'b0;
        end else begin
            perr_q      <= perr_d;
            pend_perr_q <= pend_perr_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_demux8.sv
// Randomized and directed bench for sipo_demux8: two instances (LSB first / MSB first)
// share one stimulus and are compared every cycle against a queue-based word model.
module tb_sipo_demux8;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WLEN = W + PAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, din = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
    logic       din_ready_a, din_ready_b, dv_a, dv_b, perr_a, perr_b;
    logic [2:0] sel_a, sel_b;
    logic [7:0] dout_a, dout_b;

    sipo_demux8 #(.WIDTH(W), .LSB_FIRST(1'b1), .SEL_W(3)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
        .sel_out(sel_a), .dout(dout_a), .dout_valid(dv_a), .dout_ready(dout_ready),
        .parity_err(perr_a));

    sipo_demux8 #(.WIDTH(W), .LSB_FIRST(1'b0), .SEL_W(3)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
        .sel_out(sel_b), .dout(dout_b), .dout_valid(dv_b), .dout_ready(dout_ready),
        .parity_err(perr_b));

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue of collected bits, an optional parked word, an output slot.
    bit         m_ov = 1'b0, m_perr = 1'b0, m_pend = 1'b0, m_pperr = 1'b0;
    logic [7:0] m_wa = 8'h00, m_wb = 8'h00, m_pwa = 8'h00, m_pwb = 8'h00;
    bit         bits_q[$];

    always @(posedge clk) begin : model
        bit         free;
        bit         p;
        logic [7:0] wa, wb;
        if (rst) begin
            m_ov = 1'b0; m_perr = 1'b0; m_pend = 1'b0; m_pperr = 1'b0;
            m_wa = 8'h00; m_wb = 8'h00;
            bits_q.delete();
        end else begin
            free = !m_ov || dout_ready;
            if (m_ov && dout_ready) m_ov = 1'b0;
            if (m_pend) begin
                if (free) begin
                    m_wa = m_pwa; m_wb = m_pwb; m_perr = m_pperr; m_ov = 1'b1; m_pend = 1'b0;
                end
            end else if (din_valid) begin
                bits_q.push_back(din);
                if (bits_q.size() == WLEN) begin
                    p = 1'b0;
                    for (int k = 0; k < W; k++) begin
                        wa[k]       = bits_q[k];
                        wb[W - 1 - k] = bits_q[k];
                    end
                    for (int k = 0; k < WLEN; k++) p = p ^ bits_q[k];
                    if (PAR == 0) p = 1'b0;
                    bits_q.delete();
                    if (free) begin
                        m_wa = wa; m_wb = wb; m_perr = p; m_ov = 1'b1;
                    end else begin
                        m_pwa = wa; m_pwb = wb; m_pperr = p; m_pend = 1'b1;
                    end
                end
            end
        end
    end

    bit         chk_en = 1'b0;
    logic [7:0] log_a[$], log_b[$];
    bit         logp[$];
    int         vcnt_a = 0;

    // Per-cycle comparison against the model, sampled away from the active edge.
    always @(negedge clk) begin
        int exp_sel;
        if (chk_en) begin
            exp_sel = m_pend ? 0 : ((bits_q.size() > W - 1) ? W - 1 : bits_q.size());
            chk_eq("din_ready_a", din_ready_a, !m_pend);
            chk_eq("din_ready_b", din_ready_b, !m_pend);
            chk_eq("sel_a", sel_a, exp_sel);
            chk_eq("sel_b", sel_b, exp_sel);
            chk_eq("dv_a", dv_a, m_ov);
            chk_eq("dv_b", dv_b, m_ov);
            chk_eq("dout_a", dout_a, m_wa);
            chk_eq("dout_b", dout_b, m_wb);
            chk_eq("perr_a", perr_a, m_perr);
            chk_eq("perr_b", perr_b, m_perr);
            if (dv_a) vcnt_a++;
            if (dv_a && dout_ready) begin
                log_a.push_back(dout_a);
                logp.push_back(perr_a);
            end
            if (dv_b && dout_ready) log_b.push_back(dout_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_b.delete(); logp.delete(); vcnt_a = 0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit done = 1'b0;
        din = b;
        din_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            done = din_ready_a;
            tick();
        end
        chk_eq("accept_timeout", done, 1'b1);
        din_valid = 1'b0;
        din = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [7:0] v, input bit pflip, input int maxgap);
        for (int k = 0; k < W; k++) begin
            send_bit(v[k], (maxgap > 0) ? $urandom_range(maxgap, 0) : 0);
        end
        if (PAR != 0) send_bit((^v) ^ pflip, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        chk_eq("rst_dout", dout_a, 8'h00);
        chk_eq("rst_dv", dv_a, 1'b0);
        chk_eq("rst_sel", sel_a, 3'd0);
        chk_eq("rst_ready", din_ready_a, 1'b1);
        chk_eq("rst_perr", perr_a, 1'b0);
        rst = 1'b0;

        // Streaming word with the sink always ready.
        dout_ready = 1'b1;
        clear_logs();
        send_word(8'hAA, 1'b0, 0);
        repeat (3) tick();
        chk_eq("t1_count", log_a.size(), 1);
        chk_eq("t1_word", log_a[0], 8'hAA);
        chk_eq("t1_word_b", log_b[0], 8'h55);
        chk_eq("t1_valid_cycles", vcnt_a, 1);

        // Stalled sink: second word parks, then both drain without a bubble.
        dout_ready = 1'b0;
        clear_logs();
        send_word(8'h3C, 1'b0, 0);
        send_word(8'hC3, 1'b0, 0);
        repeat (2) tick();
        chk_eq("t2_full_ready", din_ready_a, 1'b0);
        chk_eq("t2_hold_word", dout_a, 8'h3C);
        chk_eq("t2_hold_valid", dv_a, 1'b1);
        dout_ready = 1'b1;
        tick();
        chk_eq("t2_nobubble_word", dout_a, 8'hC3);
        chk_eq("t2_nobubble_valid", dv_a, 1'b1);
        repeat (3) tick();
        chk_eq("t2_count", log_a.size(), 2);
        chk_eq("t2_first", log_a[0], 8'h3C);
        chk_eq("t2_second", log_a[1], 8'hC3);
        chk_eq("t2_ready_back", din_ready_a, 1'b1);

        // Reset mid-word discards the partial bits.
        clear_logs();
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_word(8'h5A, 1'b0, 0);
        repeat (3) tick();
        chk_eq("t3_count", log_a.size(), 1);
        chk_eq("t3_word", log_a[0], 8'h5A);

        // Random idle gaps between bits.
        clear_logs();
        send_word(8'h96, 1'b0, 3);
        repeat (3) tick();
        chk_eq("t4_word", log_a[0], 8'h96);

        // MSB-first instance sees 1,0,1,0,... as 8'hAA.
        clear_logs();
        send_word(8'h55, 1'b0, 0);
        repeat (3) tick();
        chk_eq("t5_word_b", log_b[0], 8'hAA);

        // Parity status (always 0 without the parity build).
        clear_logs();
        send_word(8'hAA, 1'b0, 0);
        send_word(8'hAA, 1'b1, 0);
        repeat (3) tick();
        chk_eq("t6_count", log_a.size(), 2);
        chk_eq("t6_perr_good", logp[0], 1'b0);
        chk_eq("t6_perr_bad", logp[1], PAR);

        // Random traffic, back-pressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            din        = 1'($urandom);
            din_valid  = ($urandom_range(3, 0) != 0);
            dout_ready = ($urandom_range(3, 0) != 0);
            rst        = ($urandom_range(199, 0) == 0);
            tick();
        end
        rst = 1'b0;
        din_valid = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
